aes_rnd_engine: RTL and testbench
=================================

AES_RND_ENGINE -- requirements
Module: aes_rnd_engine

Interface
REQ-001 The block SHALL have parameter NUM_RND, default 10, meaning cipher round count; legal values are 10 (AES-128), 12 (AES-192) and 14 (AES-256), and any other value SHALL cause an elaboration error.
REQ-002 CLK  input  1  the single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  Plain_txt is valid.
REQ-005 in_ready  output  1  engine can accept a block.
REQ-006 Plain_txt  input  128  plaintext block.
REQ-007 rnd_idx  output  4  index of the round key currently required.
REQ-008 key_rnd  input  128  round key for rnd_idx, supplied combinationally by an external key store.
REQ-009 out_valid  output  1  Cypher_txt is valid.
REQ-010 out_ready  input  1  consumer accepts Cypher_txt.
REQ-011 Cypher_txt  output  128  ciphertext, registered.
REQ-012 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-013 The datapath SHALL reuse the codebase's combinational Subs_Bytes, Shift_Rows, Mix_Cols and Add_Rnd_Key blocks around a single 128-bit state register, one round per cycle.
REQ-014 The FSM SHALL have the states IDLE, RUN and DONE.
REQ-015 IDLE: in_ready=1 and rnd_idx=0; on in_valid&&in_ready the state register SHALL load Plain_txt^key_rnd, the round counter SHALL load 1, and the FSM SHALL go to RUN.
REQ-016 RUN with counter r<NUM_RND: rnd_idx=r; state SHALL load AddRndKey(MixCols(ShiftRows(SubBytes(state))), key_rnd); r increments.
REQ-017 RUN with r==NUM_RND (final round): Mix_Cols is bypassed; the result SHALL load Cypher_txt, out_valid SHALL set, and the FSM SHALL go to DONE.
REQ-018 Latency: out_valid SHALL rise exactly NUM_RND cycles after the accepting edge (10/12/14).
REQ-019 DONE: rnd_idx=0; Cypher_txt and out_valid SHALL hold stable until out_valid&&out_ready.
REQ-020 in_ready SHALL equal (IDLE) or (DONE and out_ready); in_ready SHALL be 0 throughout RUN.
REQ-021 In DONE with out_ready=1 and in_valid=0, the FSM SHALL go to IDLE and out_valid SHALL clear on the same edge.
REQ-022 In DONE with out_ready=1 and in_valid=1 (simultaneous), the output SHALL be consumed and the new block accepted on the same edge (the REQ-015 load), giving a sustained throughput of one block per NUM_RND+1 cycles.
REQ-023 in_valid while in_ready=0 SHALL be ignored, and Plain_txt SHALL not be sampled.
REQ-024 The round counter SHALL never exceed NUM_RND, and SHALL not wrap.

Reset
REQ-025 While rst_n=0, asynchronously: the FSM SHALL be IDLE, and the state register, round counter, rnd_idx and Cypher_txt SHALL be 0, out_valid 0, busy 0 and in_ready 1.
REQ-026 Reset asserted mid-RUN or in DONE SHALL abandon the block with no output produced, and the first acceptance after release SHALL behave exactly as from power-up.

Configuration
REQ-027 Macro AES_BLK_CNT_EN defined: the block SHALL add the output blk_cnt (32 bits), reset to 0, incremented on each out_valid&&out_ready, wrapping from 0xFFFFFFFF to 0.
REQ-028 Macro AES_BLK_CNT_EN undefined: the block SHALL have no blk_cnt port and no counter logic, with all other behaviour identical.

Verification
REQ-029 NUM_RND=10, key 000102..0f (bench key store indexed by rnd_idx), Plain_txt 00112233445566778899aabbccddeeff -> Cypher_txt 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid exactly 10 cycles after acceptance.
REQ-030 NUM_RND=12, key 000102..17, same plaintext -> dda97ca4864cdfe06eaf70a0ec0d7191 after 12 cycles; NUM_RND=14, key 000102..1f -> 8ea2b7ca516745bfeafc49904b496089 after 14 cycles.
REQ-031 Backpressure: hold out_ready=0 for 5 cycles after out_valid -> Cypher_txt stable, in_ready=0, in_valid pulses ignored; raise out_ready -> one handshake, then IDLE.
REQ-032 Back-to-back: keep in_valid=1 and out_ready=1 with 4 NIST blocks -> 4 correct outputs, consecutive out_valid pulses spaced NUM_RND+1 cycles.
REQ-033 Assert rst_n=0 at round 5 -> all outputs at reset values immediately; a new block after release -> the correct FIPS-197 result with nominal latency.
REQ-034 With AES_BLK_CNT_EN defined, run 3 blocks -> blk_cnt=3, and a forced preload of 0xFFFFFFFF plus one handshake -> blk_cnt=0.

Source files
------------

// File: rtl/aes_rnd_engine_if.sv
// aes_rnd_engine_if -- handshake and data bundle for aes_rnd_engine.
//   in_valid / in_ready / Plain_txt    : plaintext block acceptance
//   rnd_idx / key_rnd                  : round-key request to an external key store
//   out_valid / out_ready / Cypher_txt : ciphertext delivery
//   busy                               : engine not idle
// The slave modport is the engine; the master modport is its environment
// (block source, key store and ciphertext sink).
interface aes_rnd_engine_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] Plain_txt;
  logic [3:0]   rnd_idx;
  logic [127:0] key_rnd;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] Cypher_txt;
  logic         busy;

  modport slave (
    input  in_valid, Plain_txt, key_rnd, out_ready,
    output in_ready, rnd_idx, out_valid, Cypher_txt, busy
  );

  modport master (
    output in_valid, Plain_txt, key_rnd, out_ready,
    input  in_ready, rnd_idx, out_valid, Cypher_txt, busy
  );
endinterface

// File: rtl/aes_rnd_engine.sv
// aes_rnd_engine -- iterative AES encryption core, one round per clock.
// A single 128-bit state register is wrapped by combinational SubBytes,
// ShiftRows, MixColumns and AddRoundKey logic. Round keys come from an
// external key store addressed by rnd_idx.
// Ports:
//   CLK     : clock, rising edge
//   rst_n   : asynchronous active-low reset
//   bus     : aes_rnd_engine_if.slave (block in, round key, block out, busy)
//   blk_cnt : 32-bit count of delivered blocks (only with AES_BLK_CNT_EN)
// Parameter NUM_RND: 10, 12 or 14 rounds (AES-128/192/256).
// Optional feature macro: AES_BLK_CNT_EN.
module aes_rnd_engine #(
  parameter int NUM_RND = 10
) (
  input logic             CLK,
  input logic             rst_n,
  aes_rnd_engine_if.slave bus
`ifdef AES_BLK_CNT_EN
  ,
  output logic [31:0]     blk_cnt
`endif
);

  if (!(NUM_RND == 10 || NUM_RND == 12 || NUM_RND == 14)) begin : g_bad_num_rnd
    $error("aes_rnd_engine: NUM_RND must be 10, 12 or 14");
  end

  localparam logic [3:0] LAST_RND = 4'(NUM_RND);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = 8'h00;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      acc = b[i] ? (acc ^ aa) : acc;
      aa  = xtime(aa);
    end
    return acc;
  endfunction

  // S-box computed as the GF(2^8) inverse (x^254, which maps 0 to 0)
  // followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x2, x3, x12, t, inv;
    x2  = gf_mul(x, x);
    x3  = gf_mul(x2, x);
    x12 = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
    t   = gf_mul(x12, x3);                     // x^15
    for (int i = 0; i < 4; i++) begin
      t = gf_mul(t, t);                         // ends at x^240
    end
    inv = gf_mul(gf_mul(t, x12), x2);          // x^254
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // Byte i of a block sits at bits [127-8i -: 8]; column c holds bytes 4c..4c+3.
  function automatic logic [127:0] Subs_Bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) begin
      o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
    end
    return o;
  endfunction

  function automatic logic [127:0] Shift_Rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] Mix_Cols(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                           xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return o;
  endfunction

  function automatic logic [127:0] Add_Rnd_Key(input logic [127:0] s, input logic [127:0] k);
    return s ^ k;
  endfunction

  state_e       state_q;
  logic [127:0] blk_q;
  logic [3:0]   rnd_cnt_q;
  logic [3:0]   rnd_idx_q;
  logic [127:0] ct_q;
  logic         out_valid_q;
  logic         busy_q;
  logic [127:0] sr_s;
  logic [127:0] mix_s;
  logic [127:0] round_s;
  logic         in_ready_s;
  logic         accept_s;

  // Acceptance is possible when idle, or when the held result leaves on this same edge.
  assign in_ready_s = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.out_ready);
  assign accept_s   = bus.in_valid && in_ready_s;

  // One AES round on the state register; the last round skips MixColumns.
  always_comb begin
    sr_s = Shift_Rows(Subs_Bytes(blk_q));
    if (rnd_cnt_q == LAST_RND) begin
      mix_s = sr_s;
    end else begin
      mix_s = Mix_Cols(sr_s);
    end
    round_s = Add_Rnd_Key(mix_s, bus.key_rnd);
  end

  // Control FSM with datapath and output registers.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      blk_q       <= 128'd0;
      rnd_cnt_q   <= 4'd0;
      rnd_idx_q   <= 4'd0;
      ct_q        <= 128'd0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else if (accept_s) begin
      // rnd_idx is 0 in IDLE and DONE, so key_rnd carries the whitening key here.
      state_q     <= ST_RUN;
      blk_q       <= Add_Rnd_Key(bus.Plain_txt, bus.key_rnd);
      rnd_cnt_q   <= 4'd1;
      rnd_idx_q   <= 4'd1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_q <= ST_IDLE;
        end
        ST_RUN: begin
          if (rnd_cnt_q == LAST_RND) begin
            state_q     <= ST_DONE;
            ct_q        <= round_s;
            out_valid_q <= 1'b1;
            rnd_cnt_q   <= 4'd0;
            rnd_idx_q   <= 4'd0;
          end else begin
            blk_q     <= round_s;
            rnd_cnt_q <= rnd_cnt_q + 4'd1;
            rnd_idx_q <= rnd_cnt_q + 4'd1;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end else begin
            state_q <= ST_DONE;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          rnd_cnt_q   <= 4'd0;
          rnd_idx_q   <= 4'd0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_s;
  assign bus.rnd_idx    = rnd_idx_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.Cypher_txt = ct_q;
  assign bus.busy       = busy_q;

`ifdef AES_BLK_CNT_EN
  logic [31:0] blk_cnt_q;

  // Delivered-block counter; wraps from all-ones to zero.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      blk_cnt_q <= 32'd0;
    end else if (out_valid_q && bus.out_ready) begin
      blk_cnt_q <= blk_cnt_q + 32'd1;
    end else begin
      blk_cnt_q <= blk_cnt_q;
    end
  end

  assign blk_cnt = blk_cnt_q;
`endif

endmodule

// File: tb/tb_aes_rnd_engine.sv
// tb_aes_rnd_engine -- drives three engines (10, 12 and 14 rounds) with a
// shared stimulus; each has its own key store built by a bench-side key
// expansion. A block-level AES model predicts every output each cycle.
module tb_aes_rnd_engine;
  localparam int NI = 3;
  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;

  logic         CLK = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [127:0] Plain_txt;
  logic         out_ready;

  logic         in_ready_a  [NI];
  logic [3:0]   rnd_idx_a   [NI];
  logic         out_valid_a [NI];
  logic [127:0] ct_a        [NI];
  logic         busy_a      [NI];
  logic [127:0] rk          [NI][16];
`ifdef AES_BLK_CNT_EN
  logic [31:0]  blk_cnt_a   [NI];
`endif

  always #5 CLK = ~CLK;

  for (genvar gi = 0; gi < NI; gi++) begin : g_inst
    aes_rnd_engine_if bus ();
    assign bus.in_valid  = in_valid;
    assign bus.Plain_txt = Plain_txt;
    assign bus.out_ready = out_ready;
    assign bus.key_rnd   = rk[gi][bus.rnd_idx];
    assign in_ready_a[gi]  = bus.in_ready;
    assign rnd_idx_a[gi]   = bus.rnd_idx;
    assign out_valid_a[gi] = bus.out_valid;
    assign ct_a[gi]        = bus.Cypher_txt;
    assign busy_a[gi]      = bus.busy;
    aes_rnd_engine #(.NUM_RND(10 + 2*gi)) u_dut (
      .CLK   (CLK),
      .rst_n (rst_n),
      .bus   (bus)
`ifdef AES_BLK_CNT_EN
      ,
      .blk_cnt (blk_cnt_a[gi])
`endif
    );
  end

  int           n_pass, n_tot, cyc;
  logic [7:0]   sb [256];
  logic [127:0] exp_ct [NI];
  bit           m_run [NI], m_done [NI], ov_prev [NI], b2b;
  int           m_k [NI], m_acc [NI], last_rise [NI], hs_cnt [NI], hs_snap [NI];
  logic [127:0] m_pend [NI], m_ct [NI];
  logic [31:0]  m_bc [NI];

  function automatic int nr_of(input int i);
    return 10 + 2*i;
  endfunction

  task automatic chk(input string nm, input int inst, input logic [127:0] act, input logic [127:0] expv);
    n_tot++;
    if (act === expv) n_pass++;
    else $display("FAIL %s[%0d] t=%0t: got %0h expected %0h", nm, inst, $time, act, expv);
  endtask

  // S-box table from the multiplicative generator 3 and its inverse.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      q = q[7] ? (q ^ 8'h09) : q;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
  endtask

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Key schedule for key bytes 00 01 02 ... (16/24/32 bytes).
  task automatic expand_keys();
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int nk, nw;
    for (int i = 0; i < NI; i++) begin
      nk = 4 + 2*i;
      nw = 4 * (nr_of(i) + 1);
      rc = 8'h01;
      for (int j = 0; j < nk; j++) w[j] = {8'(4*j), 8'(4*j+1), 8'(4*j+2), 8'(4*j+3)};
      for (int j = nk; j < nw; j++) begin
        t = w[j-1];
        if (j % nk == 0) begin
          t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
        end else if (nk > 6 && j % nk == 4) begin
          t = subw(t);
        end
        w[j] = w[j-nk] ^ t;
      end
      for (int r = 0; r < 16; r++)
        rk[i][r] = (r <= nr_of(i)) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'd0;
    end
  endtask

  // Whole-block AES encryption on a byte array (byte 4c+r = row r, column c).
  function automatic logic [127:0] aes_model(input logic [127:0] pt, input int i);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] o;
    int n = nr_of(i);
    for (int k = 0; k < 16; k++) s[k] = pt[127-8*k -: 8] ^ rk[i][0][127-8*k -: 8];
    for (int rd = 1; rd <= n; rd++) begin
      for (int k = 0; k < 16; k++) t[k] = sb[s[k]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[4*c+r] = t[4*((c+r)%4)+r];
      if (rd != n) begin
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++)
            t[4*c+r] = gm(8'h02, s[4*c+r]) ^ gm(8'h03, s[4*c+(r+1)%4]) ^
                       s[4*c+(r+2)%4] ^ s[4*c+(r+3)%4];
        for (int k = 0; k < 16; k++) s[k] = t[k];
      end
      for (int k = 0; k < 16; k++) s[k] = s[k] ^ rk[i][rd][127-8*k -: 8];
    end
    for (int k = 0; k < 16; k++) o[127-8*k -: 8] = s[k];
    return o;
  endfunction

  // Per-cycle comparison for one engine, then advance its expectation past the next edge.
  task automatic step(input int i);
    int n = nr_of(i);
    bit er;
    if (!rst_n) begin
      chk("rst_in_ready", i, 128'(in_ready_a[i]), 128'd1);
      chk("rst_rnd_idx", i, 128'(rnd_idx_a[i]), 128'd0);
      chk("rst_out_valid", i, 128'(out_valid_a[i]), 128'd0);
      chk("rst_busy", i, 128'(busy_a[i]), 128'd0);
      chk("rst_cypher", i, ct_a[i], 128'd0);
`ifdef AES_BLK_CNT_EN
      chk("rst_blk_cnt", i, 128'(blk_cnt_a[i]), 128'd0);
      m_bc[i] = 32'd0;
`endif
      m_run[i] = 1'b0;
      m_done[i] = 1'b0;
      ov_prev[i] = 1'b0;
    end else begin
      er = (!m_run[i] && !m_done[i]) || (m_done[i] && out_ready);
      chk("in_ready", i, 128'(in_ready_a[i]), 128'(er));
      chk("rnd_idx", i, 128'(rnd_idx_a[i]), m_run[i] ? 128'(m_k[i]) : 128'd0);
      chk("out_valid", i, 128'(out_valid_a[i]), 128'(m_done[i]));
      chk("busy", i, 128'(busy_a[i]), 128'(m_run[i] || m_done[i]));
      if (m_done[i]) chk("cypher", i, ct_a[i], m_ct[i]);
      if (out_valid_a[i] && !ov_prev[i]) begin
        chk("latency", i, 128'(cyc - m_acc[i]), 128'(n));
        if (b2b && last_rise[i] >= 0) chk("spacing", i, 128'(cyc - last_rise[i]), 128'(n + 1));
        last_rise[i] = cyc;
      end
      ov_prev[i] = out_valid_a[i];
`ifdef AES_BLK_CNT_EN
      chk("blk_cnt", i, 128'(blk_cnt_a[i]), 128'(m_bc[i]));
`endif
      if (m_run[i]) begin
        if (m_k[i] == n) begin
          m_run[i] = 1'b0;
          m_done[i] = 1'b1;
          m_ct[i] = m_pend[i];
        end else begin
          m_k[i]++;
        end
      end else if (m_done[i] && out_ready) begin
        m_done[i] = 1'b0;
        hs_cnt[i]++;
        m_bc[i] = m_bc[i] + 32'd1;
      end
      if (in_valid && er) begin
        m_run[i] = 1'b1;
        m_k[i] = 1;
        m_pend[i] = aes_model(Plain_txt, i);
        m_acc[i] = cyc + 1;
      end
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    cyc++;
    for (int i = 0; i < NI; i++) step(i);
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_ov(input int i, input int bound);
    int w = 0;
    while (!out_valid_a[i] && w < bound) begin
      tick();
      w++;
    end
    chk("wait_out_valid", i, 128'(out_valid_a[i]), 128'd1);
  endtask

  initial begin
    int lat;
    n_pass = 0; n_tot = 0; cyc = 0; b2b = 1'b0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; Plain_txt = 128'd0;
    exp_ct[0] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    exp_ct[1] = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    exp_ct[2] = 128'h8ea2b7ca516745bfeafc49904b496089;
    for (int i = 0; i < NI; i++) begin
      m_run[i] = 1'b0; m_done[i] = 1'b0; ov_prev[i] = 1'b0;
      last_rise[i] = -1; hs_cnt[i] = 0; m_bc[i] = 32'd0; m_acc[i] = 0; m_k[i] = 0;
    end
    build_sbox();
    expand_keys();

    // Pin the model to published values.
    chk("sbox_00", 0, 128'(sb[0]), 128'h63);
    chk("sbox_53", 0, 128'(sb[8'h53]), 128'hed);
    chk("rk128_10", 0, rk[0][10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    for (int i = 0; i < NI; i++) chk("model_fips197", i, aes_model(PT, i), exp_ct[i]);

    // Reset, then one FIPS-197 block held under backpressure.
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    Plain_txt = PT; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0; Plain_txt = 128'd0;
    wait_ov(2, 20);
    for (int c = 0; c < 5; c++) begin
      in_valid = c[0];
      Plain_txt = {$urandom(), $urandom(), $urandom(), $urandom()};
      tick();
    end
    for (int i = 0; i < NI; i++) begin
      chk("held_cypher", i, ct_a[i], exp_ct[i]);
      chk("held_in_ready", i, 128'(in_ready_a[i]), 128'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    for (int i = 0; i < NI; i++) chk("idle_after_hs", i, 128'(busy_a[i]), 128'd0);

    // Reset in the middle of round 5, then a clean block.
    Plain_txt = PT; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    chk("rnd_idx_round5", 0, 128'(rnd_idx_a[0]), 128'd5);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk("async_rst_busy", i, 128'(busy_a[i]), 128'd0);
      chk("async_rst_rnd_idx", i, 128'(rnd_idx_a[i]), 128'd0);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    Plain_txt = PT; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid_a[0] && lat < 20) begin
      tick();
      lat++;
    end
    chk("post_reset_latency", 0, 128'(lat), 128'd10);
    chk("post_reset_cypher", 0, ct_a[0], exp_ct[0]);
    repeat (6) tick();

    // Back-to-back with in_valid and out_ready held high.
    b2b = 1'b1;
    for (int i = 0; i < NI; i++) begin
      last_rise[i] = -1;
      hs_snap[i] = hs_cnt[i];
    end
    in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 65; c++) begin
      Plain_txt = PT ^ {96'd0, 32'(c)};
      tick();
    end
    in_valid = 1'b0;
    repeat (16) tick();
    b2b = 1'b0;
    for (int i = 0; i < NI; i++) chk("b2b_blocks_ge4", i, 128'(hs_cnt[i] - hs_snap[i] >= 4), 128'd1);

`ifdef AES_BLK_CNT_EN
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int b = 0; b < 3; b++) begin
      Plain_txt = PT; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (16) tick();
    end
    for (int i = 0; i < NI; i++) chk("blk_cnt_three", i, 128'(blk_cnt_a[i]), 128'd3);
    force g_inst[0].u_dut.blk_cnt_q = 32'hffffffff;
    #1;
    release g_inst[0].u_dut.blk_cnt_q;
    m_bc[0] = 32'hffffffff;
    Plain_txt = PT; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (16) tick();
    chk("blk_cnt_wrap", 0, 128'(blk_cnt_a[0]), 128'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
